// File: rtl/wfg_stim_ramp_if.sv
// Signal bundle for the ramp stimulus block: Wishbone slave bus plus AXI-Stream sample output.
// The block itself keeps flat ports so it drops into existing wrappers unchanged.
interface wfg_stim_ramp_if #(
  parameter int BUSW = 32
);
  logic [BUSW-1:0] adr;
  logic [BUSW-1:0] datwr;
  logic [BUSW-1:0] datrd;
  logic            we;
  logic            stb;
  logic            cyc;
  logic            ack;
  logic            tready;
  logic            tvalid;
  logic [31:0]     tdata;

  modport master (
    output adr, datwr, we, stb, cyc, tready,
    input  datrd, ack, tvalid, tdata
  );

  modport slave (
    input  adr, datwr, we, stb, cyc, tready,
    output datrd, ack, tvalid, tdata
  );
endinterface

// File: rtl/wfg_stim_ramp.sv
// Sawtooth ramp stimulus generator: Wishbone-programmed START/END/INC, one sample per
// AXI-Stream handshake, wrapping to START on overflow or when the next value passes END.
module wfg_stim_ramp #(
  parameter int BUSW = 32
) (
  input  logic            io_wbs_clk,
  input  logic            io_wbs_rst_n,
  input  logic [BUSW-1:0] io_wbs_adr,
  input  logic [BUSW-1:0] io_wbs_datwr,
  output logic [BUSW-1:0] io_wbs_datrd,
  input  logic            io_wbs_we,
  input  logic            io_wbs_stb,
  input  logic            io_wbs_cyc,
  output logic            io_wbs_ack,
  input  logic            wfg_axis_tready_i,
  output logic            wfg_axis_tvalid_o,
  output logic [31:0]     wfg_axis_tdata_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  logic        ctrl_en;
  logic [15:0] inc_val;
  logic [15:0] start_val;
  logic [15:0] end_val;

  logic        bus_req;
  logic [15:0] rd_mux;

  state_t      state;
  logic [15:0] ramp;
  logic [16:0] step_sum;
  logic [15:0] ramp_next;

  logic        unused_bits;
  assign unused_bits = ^{io_wbs_adr[BUSW-1:4], io_wbs_adr[1:0], io_wbs_datwr[BUSW-1:16]};

  // A request is only taken while ack is low, so back-to-back strobes yield ack, gap, ack.
  assign bus_req = io_wbs_cyc & io_wbs_stb & ~io_wbs_ack;

  always_comb begin
    rd_mux = '0;
    case (io_wbs_adr[3:2])
      2'd0: rd_mux = {15'h0000, ctrl_en};
      2'd1: rd_mux = inc_val;
      2'd2: rd_mux = start_val;
      2'd3: rd_mux = end_val;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      io_wbs_ack   <= 1'b0;
      io_wbs_datrd <= '0;
      ctrl_en      <= 1'b0;
      inc_val      <= '0;
      start_val    <= '0;
      end_val      <= '0;
    end else begin
      io_wbs_ack   <= bus_req;
      io_wbs_datrd <= '0;
      if (bus_req && !io_wbs_we) begin
        io_wbs_datrd <= BUSW'(rd_mux);
      end
      if (bus_req && io_wbs_we) begin
        case (io_wbs_adr[3:2])
          2'd0: ctrl_en   <= io_wbs_datwr[0];
          2'd1: inc_val   <= io_wbs_datwr[15:0];
          2'd2: start_val <= io_wbs_datwr[15:0];
          2'd3: end_val   <= io_wbs_datwr[15:0];
          default: ;
        endcase
      end
    end
  end

  // 17-bit sum keeps the carry so a wrap past 0xFFFF reloads START instead of aliasing low.
  always_comb begin
    step_sum  = {1'b0, ramp} + {1'b0, inc_val};
    ramp_next = step_sum[15:0];
    if (step_sum[16] || (step_sum[15:0] > end_val)) begin
      ramp_next = start_val;
    end
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      state             <= IDLE;
      ramp              <= '0;
      wfg_axis_tvalid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_en) begin
            ramp              <= start_val;
            wfg_axis_tvalid_o <= 1'b1;
            state             <= RUN;
          end
        end
        RUN: begin
          // A handshake on the disabling edge still consumes the sample.
          if (wfg_axis_tvalid_o && wfg_axis_tready_i) begin
            ramp <= ramp_next;
          end
          if (!ctrl_en) begin
            wfg_axis_tvalid_o <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wfg_axis_tdata_o = {16'h0000, ramp};

endmodule

// File: tb/tb_wfg_stim_ramp.sv
// Self-checking bench for wfg_stim_ramp: register table, scoreboarded ramp sequences,
// stall/disable/reset corner cases.
module tb_wfg_stim_ramp;

  logic clk;
  logic rst_n;

  wfg_stim_ramp_if #(.BUSW(32)) bus ();

  wfg_stim_ramp #(.BUSW(32)) dut (
    .io_wbs_clk        (clk),
    .io_wbs_rst_n      (rst_n),
    .io_wbs_adr        (bus.adr),
    .io_wbs_datwr      (bus.datwr),
    .io_wbs_datrd      (bus.datrd),
    .io_wbs_we         (bus.we),
    .io_wbs_stb        (bus.stb),
    .io_wbs_cyc        (bus.cyc),
    .io_wbs_ack        (bus.ack),
    .wfg_axis_tready_i (bus.tready),
    .wfg_axis_tvalid_o (bus.tvalid),
    .wfg_axis_tdata_o  (bus.tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] sb[$];
  logic        b2b = 1'b0;
  logic        have_last = 1'b0;
  int unsigned cyc_cnt = 0;
  int unsigned last_pop = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } reg_vec_t;

  reg_vec_t vecs[8];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] model_step(input logic [15:0] r, input logic [15:0] s,
                                             input logic [15:0] e, input logic [15:0] i);
    int unsigned sum;
    sum = 32'(r) + 32'(i);
    if (sum > 32'd65535) return s;
    if (sum > 32'(e)) return s;
    return 16'(sum);
  endfunction

  // Stream monitor: signals sampled at negedge are the ones seen by the next active edge.
  always @(negedge clk) begin
    logic [31:0] exp;
    cyc_cnt++;
    if (rst_n && bus.tvalid && bus.tready && sb.size() > 0) begin
      exp = sb.pop_front();
      check("stream tdata", bus.tdata, exp);
      if (b2b && have_last) check("stream gap", cyc_cnt - last_pop, 32'd1);
      last_pop  = cyc_cnt;
      have_last = 1'b1;
    end
  end

  task automatic wb_xfer(input logic w, input logic [1:0] idx, input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    @(posedge clk); #1;
    bus.adr   = 32'hA5A5_0100 | (32'(idx) << 2);
    bus.datwr = d;
    bus.we    = w;
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    for (n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (bus.ack) break;
    end
    check("ack latency", 32'(n), 32'd0);
    q = bus.datrd;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
    @(posedge clk); #1;
    check("ack width", 32'(bus.ack), 32'd0);
    check("datrd idle", bus.datrd, 32'd0);
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, idx, d, q);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && sb.size() > 0; k++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL %s: got %0d samples outstanding expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic run_ramp(input string name, input logic [15:0] s, input logic [15:0] e,
                          input logic [15:0] i, input int n);
    logic [15:0] r;
    r = s;
    wb_write(2'd2, 32'(s));
    wb_write(2'd3, 32'(e));
    wb_write(2'd1, 32'(i));
    bus.tready = 1'b1;
    have_last  = 1'b0;
    b2b        = 1'b1;
    for (int k = 0; k < n; k++) begin
      sb.push_back(32'(r));
      r = model_step(r, s, e, i);
    end
    wb_write(2'd0, 32'd1);
    drain(name);
    b2b        = 1'b0;
    bus.tready = 1'b0;
    wb_write(2'd0, 32'd0);
    @(posedge clk); #1;
    check("idle after run", 32'(bus.tvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [31:0] held;

    vecs[0] = '{2'd1, 32'hABCD_1234, 32'h0000_1234};
    vecs[1] = '{2'd2, 32'h5555_AAAA, 32'h0000_AAAA};
    vecs[2] = '{2'd3, 32'hFFFF_0F0F, 32'h0000_0F0F};
    vecs[3] = '{2'd0, 32'h0000_0003, 32'h0000_0001};
    vecs[4] = '{2'd0, 32'hFFFF_FFFE, 32'h0000_0000};
    vecs[5] = '{2'd1, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vecs[7] = '{2'd3, 32'h1234_8001, 32'h0000_8001};

    rst_n      = 1'b0;
    bus.adr    = '0;
    bus.datwr  = '0;
    bus.we     = 1'b0;
    bus.stb    = 1'b0;
    bus.cyc    = 1'b0;
    bus.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tvalid", 32'(bus.tvalid), 32'd0);
    check("reset tdata", bus.tdata, 32'd0);
    check("reset ack", 32'(bus.ack), 32'd0);
    check("reset datrd", bus.datrd, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      wb_write(vecs[v].idx, vecs[v].wdata);
      wb_xfer(1'b0, vecs[v].idx, 32'd0, q);
      check($sformatf("readback %0d", v), q, vecs[v].rexp);
    end
    check("no stream after table", 32'(bus.tvalid), 32'd0);

    // Held strobe: ack must toggle 1,0,1,0 with data only during ack.
    wb_write(2'd1, 32'h0000_BEEF);
    @(posedge clk); #1;
    bus.adr = 32'h0000_0004;
    bus.we  = 1'b0;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("held ack %0d", k), 32'(bus.ack), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("held datrd %0d", k), bus.datrd, (k % 2 == 0) ? 32'h0000_BEEF : 32'd0);
    end
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    @(posedge clk); #1;

    run_ramp("basic ramp", 16'h0010, 16'h0040, 16'h0010, 6);
    run_ramp("carry wrap", 16'hFFF0, 16'hFFFF, 16'h0020, 3);
    run_ramp("zero inc", 16'h1234, 16'h2000, 16'h0000, 4);
    run_ramp("start gt end", 16'h0050, 16'h0010, 16'h0001, 3);

    // Stall with a mid-stall INC change: frozen output, new step applies after the held sample.
    wb_write(2'd2, 32'h0000_0100);
    wb_write(2'd3, 32'h0000_1000);
    wb_write(2'd1, 32'h0000_0001);
    for (int k = 0; k < 5; k++) sb.push_back(32'h0000_0100 + 32'(k));
    wb_write(2'd0, 32'd1);
    bus.tready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 1; k++) begin
      @(posedge clk); #1;
    end
    bus.tready = 1'b0;
    check("stall queue head", 32'(sb.size()), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall tvalid %0d", k), 32'(bus.tvalid), 32'd1);
      check($sformatf("stall tdata %0d", k), bus.tdata, 32'h0000_0104);
    end
    wb_write(2'd1, 32'h0000_0003);
    @(negedge clk);
    check("tdata after inc write", bus.tdata, 32'h0000_0104);
    sb.push_back(32'h0000_0107);
    sb.push_back(32'h0000_010A);
    @(posedge clk); #1;
    bus.tready = 1'b1;
    drain("stall resume");

    // Disable while streaming: last handshake counts, tvalid drops the edge after ack.
    for (int k = 0; k < 40; k++) sb.push_back(32'h0000_010D + 32'(3 * k));
    @(posedge clk); #1;
    bus.adr   = 32'h0000_0000;
    bus.datwr = 32'h0000_0000;
    bus.we    = 1'b1;
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    @(posedge clk); #1;
    check("disable ack", 32'(bus.ack), 32'd1);
    check("tvalid at ack", 32'(bus.tvalid), 32'd1);
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
    @(posedge clk); #1;
    check("tvalid after disable", 32'(bus.tvalid), 32'd0);
    check("ramp held after disable", bus.tdata, sb[0]);
    sb.delete();
    sb.push_back(32'h0000_0100);
    sb.push_back(32'h0000_0103);
    have_last = 1'b0;
    wb_write(2'd0, 32'd1);
    drain("restart from start");

    // Asynchronous reset mid-stream and mid-transfer.
    @(posedge clk); #1;
    bus.adr = 32'h0000_0000;
    bus.we  = 1'b0;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    @(posedge clk); #3;
    check("ack before reset", 32'(bus.ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset tvalid", 32'(bus.tvalid), 32'd0);
    check("async reset tdata", bus.tdata, 32'd0);
    check("async reset ack", 32'(bus.ack), 32'd0);
    check("async reset datrd", bus.datrd, 32'd0);
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no sample after reset", 32'(bus.tvalid), 32'd0);
    check("no ack after reset", 32'(bus.ack), 32'd0);
    wb_xfer(1'b0, 2'd0, 32'd0, q);
    check("ctrl after reset", q, 32'd0);
    wb_xfer(1'b0, 2'd2, 32'd0, q);
    check("start after reset", q, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
